power_switch_sequencer: RTL and testbench
=========================================

# power_switch_sequencer

Sequences a bank of `N_SW` switch-level PMOS header/NMOS footer cells that gate the supply to a logic island. Turns switch segments on one at a time with a programmable gap to limit inrush current, and holds the island's output isolation until the rail has settled. On power-down it asserts isolation first, then turns segments off in reverse order. Sits between the block-level power request logic and the switch-cell bank.

## Interface
- `N_SW`, default 8: number of switch segments (≥2).
- `DLY_W`, default 8: width of the step-gap field.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `pwr_req` input 1: level request; 1 = island powered, 0 = island off.
- `step_dly` input DLY_W: gap between segment steps, in cycles minus one.
- `sw_en` output N_SW: segment enables, active-high, thermometer-coded from bit 0.
- `sw_cnt` output clog2(N_SW+1): number of segments currently enabled.
- `iso_en` output 1: isolation clamp enable, active-high.
- `pwr_ack` output 1: 1 only when all segments are on and isolation is released.
- `busy` output 1: 1 while ramping or settling.

## Operation
- States:
  - OFF: `sw_en`=0, `iso_en`=1, `pwr_ack`=0, `busy`=0.
  - RAMP_UP.
  - SETTLE: all segments on, waiting.
  - ON: `iso_en`=0, `pwr_ack`=1.
  - RAMP_DOWN.
- Gap counter:
  - Reloaded from `step_dly` on every segment change and on every state entry.
  - A step fires when the counter reads 0.
  - `step_dly` is sampled only at reload. Changes mid-gap take effect at the next reload.
- OFF → RAMP_UP when `pwr_req`=1. `sw_en[0]` is set on the same edge. Each later step sets the next bit.
- RAMP_UP → SETTLE on the edge that sets `sw_en[N_SW-1]`.
- SETTLE → ON when the counter expires: `iso_en`=0 and `pwr_ack`=1 on the same edge.
- ON → RAMP_DOWN when `pwr_req`=0: `iso_en`=1 and `pwr_ack`=0 on that edge. No segment changes on that edge.
- RAMP_DOWN: each step clears the highest set bit. The edge that clears `sw_en[0]` enters OFF.
- Abort up (`pwr_req`=0 in RAMP_UP or SETTLE):
  - Enter RAMP_DOWN on that edge and reload the counter.
  - The highest set bit clears one gap later.
  - `iso_en` stays 1 throughout.
- Abort down (`pwr_req`=1 in RAMP_DOWN):
  - Enter RAMP_UP on that edge and reload the counter.
  - The lowest cleared bit sets one gap later.
  - If `sw_en` is already 0 at that point, this behaves as OFF → RAMP_UP: bit 0 sets on that edge.
- Invariants:
  - `sw_en` is always thermometer code.
  - `sw_cnt` always equals popcount(`sw_en`).
  - At most one bit changes per edge.
  - `iso_en`=0 only in ON.
  - `pwr_ack` == (state==ON).
  - `busy` == (state ∈ {RAMP_UP, SETTLE, RAMP_DOWN}).
- Width rules:
  - The gap counter is DLY_W bits and never wraps. It holds at 0 until reloaded.
  - `sw_cnt` saturates at N_SW by construction.

## Timing
- Reset: `rst_n`=0 at an edge forces OFF immediately from any state. After that edge: `sw_en`=0, `sw_cnt`=0, `iso_en`=1, `pwr_ack`=0, `busy`=0, counter=0.
  - A mid-ramp reset drops every segment in one cycle; the supply network design accepts this.
- Notation: gap g = `step_dly`+1 cycles (g=1 when `step_dly`=0).
- Power-up, with E0 = the edge where OFF samples `pwr_req`=1:
  - `sw_en[k]` sets at E0+k·g.
  - `iso_en` falls and `pwr_ack` rises at E0+N_SW·g.
- Power-down, with F0 = the edge where ON samples `pwr_req`=0:
  - `iso_en` rises at F0.
  - `sw_en[k]` clears at F0+(N_SW−k)·g.
  - OFF is entered at F0+N_SW·g.
- Minimum isolation lead before the first segment turns off is g cycles.
- `pwr_req` is a level, sampled every edge. Pulses shorter than one cycle are not supported. No synchronizer is included.

## Test plan
- Clean power-up: N_SW=8, step_dly=3, `pwr_req` 0→1 at E0 → `sw_en` steps 0x01, 0x03 … 0xFF at E0+0, 4 … 28; `pwr_ack`=1 and `iso_en`=0 at E0+32; `busy`=0 from E0+32.
- Clean power-down from ON: step_dly=3, `pwr_req`=0 at F0 → `iso_en`=1 and `pwr_ack`=0 at F0; `sw_en` 0x7F at F0+4 … 0x00 at F0+32; OFF at F0+32.
- Abort during ramp: step_dly=1, drop `pwr_req` when `sw_en`=0x07 (edge A) → 0x03 at A+2, 0x01 at A+4, 0x00 at A+6; `iso_en` stays 1 and `pwr_ack` stays 0 throughout.
- Re-request during ramp-down: step_dly=0, `pwr_req`=1 when `sw_en`=0x0F (edge A) → 0x1F at A+1, 0xFF at A+4, `pwr_ack`=1 at A+5.
- Reset mid-operation:
  - With `sw_en`=0x3F in RAMP_UP, assert `rst_n`=0 for one edge → `sw_en`=0, `iso_en`=1, `pwr_ack`=0, `busy`=0 next cycle.
  - With `pwr_req` held 1, the sequence restarts: bit 0 sets on the first edge with `rst_n`=1.
- step_dly change mid-ramp: start with step_dly=5, change it to 0 two cycles after bit 0 sets → bit 1 still sets 6 cycles after bit 0; later bits are spaced 1 cycle apart.

Source files
------------

// File: rtl/power_switch_sequencer.sv
// Power-switch sequencer for a gated logic island.
// Turns switch segments on one per gap to limit inrush, releases isolation
// only after the rail has settled, and reverses the order on power-down.
// The enable bank is kept as a segment count, so the thermometer code and
// the popcount output cannot disagree.
module power_switch_sequencer #(
   parameter int N_SW  = 8,
   parameter int DLY_W = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         pwr_req,
   input  logic [DLY_W-1:0]             step_dly,
   output logic [N_SW-1:0]              sw_en,
   output logic [$clog2(N_SW+1)-1:0]    sw_cnt,
   output logic                         iso_en,
   output logic                         pwr_ack,
   output logic                         busy
);

   localparam int CW = $clog2(N_SW + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(N_SW);
   localparam logic [CW-1:0] CNT_LAST = CW'(N_SW - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      S_OFF,
      S_RAMP_UP,
      S_SETTLE,
      S_ON,
      S_RAMP_DOWN
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     sw_cnt_q, sw_cnt_d;
   logic [DLY_W-1:0]  gap_q, gap_d;
   logic              reload;
   logic              gap_done;

   // State, segment count and gap counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_OFF;
         sw_cnt_q <= '0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         sw_cnt_q <= sw_cnt_d;
         gap_q    <= gap_d;
      end
   end

   // Next-state, segment stepping, gap reload and output decode.
   always_comb begin
      state_d  = state_q;
      sw_cnt_d = sw_cnt_q;
      reload   = 1'b0;
      gap_done = (gap_q == '0);
      // Gap counter runs down and holds at zero until the next reload.
      gap_d    = gap_done ? '0 : gap_q - DLY_W'(1);

      unique case (state_q)
         S_OFF: begin
            if (pwr_req) begin
               state_d  = S_RAMP_UP;
               sw_cnt_d = CNT_ONE;
               reload   = 1'b1;
            end
         end
         S_RAMP_UP: begin
            // A dropped request takes priority over a due step.
            if (!pwr_req) begin
               state_d = S_RAMP_DOWN;
               reload  = 1'b1;
            end else if (gap_done) begin
               reload = 1'b1;
               if (sw_cnt_q == CNT_FULL) begin
                  // Re-request caught the bank still fully on: nothing left
                  // to switch, so the gap just served as the settle time.
                  state_d = S_ON;
               end else begin
                  sw_cnt_d = sw_cnt_q + CNT_ONE;
                  if (sw_cnt_q == CNT_LAST) begin
                     state_d = S_SETTLE;
                  end
               end
            end
         end
         S_SETTLE: begin
            if (!pwr_req) begin
               state_d = S_RAMP_DOWN;
               reload  = 1'b1;
            end else if (gap_done) begin
               state_d = S_ON;
               reload  = 1'b1;
            end
         end
         S_ON: begin
            // Isolation goes up on this edge; segments stay put for one gap.
            if (!pwr_req) begin
               state_d = S_RAMP_DOWN;
               reload  = 1'b1;
            end
         end
         S_RAMP_DOWN: begin
            if (pwr_req) begin
               state_d = S_RAMP_UP;
               reload  = 1'b1;
               if (sw_cnt_q == '0) begin
                  sw_cnt_d = CNT_ONE;
               end
            end else if (gap_done) begin
               reload = 1'b1;
               if (sw_cnt_q != '0) begin
                  sw_cnt_d = sw_cnt_q - CNT_ONE;
               end
               if (sw_cnt_q <= CNT_ONE) begin
                  state_d = S_OFF;
               end
            end
         end
         default: begin
            state_d  = S_OFF;
            sw_cnt_d = '0;
            reload   = 1'b1;
         end
      endcase

      if (reload) begin
         gap_d = step_dly;
      end

      sw_en = '0;
      for (int i = 0; i < N_SW; i++) begin
         sw_en[i] = (i < int'(sw_cnt_q));
      end
      sw_cnt  = sw_cnt_q;
      iso_en  = (state_q != S_ON);
      pwr_ack = (state_q == S_ON);
      busy    = (state_q == S_RAMP_UP) || (state_q == S_SETTLE) ||
                (state_q == S_RAMP_DOWN);
   end

endmodule

// File: tb/tb_power_switch_sequencer.sv
// Bench for power_switch_sequencer: directed scenarios from the power-up,
// power-down, abort and reset sequences, then a long randomized run against
// a time-based reference model (segment level plus absolute step deadline).
module tb_power_switch_sequencer;

   localparam int N  = 8;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pwr_req;
   logic [DW-1:0] step_dly;
   logic [N-1:0]  sw_en;
   logic [3:0]    sw_cnt;
   logic          iso_en;
   logic          pwr_ack;
   logic          busy;

   int checks = 0;
   int fails  = 0;

   // Reference model state.
   int m_n;
   bit m_on;
   bit m_act;
   bit m_up;
   int m_due;
   int m_t;

   power_switch_sequencer #(.N_SW(N), .DLY_W(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pwr_req  (pwr_req),
      .step_dly (step_dly),
      .sw_en    (sw_en),
      .sw_cnt   (sw_cnt),
      .iso_en   (iso_en),
      .pwr_ack  (pwr_ack),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] therm(input int n);
      logic [N:0] t;
      t = (({{N{1'b0}}, 1'b1}) << n) - 1;
      return t[N-1:0];
   endfunction

   // Model: n segments on; while active, the next step is allowed at m_due.
   task automatic model_edge(input logic rq, input logic [DW-1:0] sd, input logic rn);
      int g;
      g = int'(sd) + 1;
      if (!rn) begin
         m_n = 0; m_on = 0; m_act = 0; m_up = 0; m_due = 0;
      end else if (!m_act && !m_on) begin
         if (rq) begin
            m_n = 1; m_act = 1; m_up = 1; m_due = m_t + g;
         end
      end else if (m_on) begin
         if (!rq) begin
            m_on = 0; m_act = 1; m_up = 0; m_due = m_t + g;
         end
      end else if (rq != m_up) begin
         m_up  = rq;
         m_due = m_t + g;
         if (rq && m_n == 0) m_n = 1;
      end else if (m_t >= m_due) begin
         if (m_up) begin
            if (m_n == N) begin
               m_on = 1; m_act = 0;
            end else begin
               m_n++; m_due = m_t + g;
            end
         end else begin
            m_n--; m_due = m_t + g;
            if (m_n == 0) m_act = 0;
         end
      end
      m_t++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pwr_req = 1'b0; step_dly = '0;
      tick(); tick();
      checks += 5;
      if (sw_en !== '0)      begin fails++; $display("FAIL rst_sw_en got=%h exp=00", sw_en); end
      if (sw_cnt !== 4'd0)   begin fails++; $display("FAIL rst_sw_cnt got=%0d exp=0", sw_cnt); end
      if (iso_en !== 1'b1)   begin fails++; $display("FAIL rst_iso got=%b exp=1", iso_en); end
      if (pwr_ack !== 1'b0)  begin fails++; $display("FAIL rst_ack got=%b exp=0", pwr_ack); end
      if (busy !== 1'b0)     begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
      rst_n = 1'b1;
      tick();
      checks++;
      if (sw_en !== '0) begin fails++; $display("FAIL idle_sw_en got=%h exp=00", sw_en); end
   endtask

   task automatic test_power_up();
      int n;
      step_dly = 8'd3; pwr_req = 1'b1;
      for (int e = 0; e <= 32; e++) begin
         tick();
         n = (e / 4 + 1 > N) ? N : e / 4 + 1;
         checks += 4;
         if (sw_en !== therm(n))        begin fails++; $display("FAIL pu_sw_en e=%0d got=%h exp=%h", e, sw_en, therm(n)); end
         if (sw_cnt !== 4'(n))          begin fails++; $display("FAIL pu_sw_cnt e=%0d got=%0d exp=%0d", e, sw_cnt, n); end
         if (pwr_ack !== (e >= 32))     begin fails++; $display("FAIL pu_ack e=%0d got=%b exp=%b", e, pwr_ack, e >= 32); end
         if (iso_en !== (e < 32) || busy !== (e < 32)) begin
            fails++; $display("FAIL pu_iso_busy e=%0d got=%b%b exp=%b%b", e, iso_en, busy, e < 32, e < 32);
         end
      end
   endtask

   task automatic test_power_down();
      int n;
      tick(); tick();
      checks++;
      if (pwr_ack !== 1'b1) begin fails++; $display("FAIL on_hold_ack got=%b exp=1", pwr_ack); end
      pwr_req = 1'b0;
      for (int e = 0; e <= 32; e++) begin
         tick();
         n = N - e / 4;
         checks += 3;
         if (sw_en !== therm(n))  begin fails++; $display("FAIL pd_sw_en e=%0d got=%h exp=%h", e, sw_en, therm(n)); end
         if (iso_en !== 1'b1 || pwr_ack !== 1'b0) begin
            fails++; $display("FAIL pd_iso_ack e=%0d got=%b%b exp=10", e, iso_en, pwr_ack);
         end
         if (busy !== (e < 32))   begin fails++; $display("FAIL pd_busy e=%0d got=%b exp=%b", e, busy, e < 32); end
      end
   endtask

   task automatic test_abort_up();
      int n;
      bit hit;
      step_dly = 8'd1; pwr_req = 1'b1;
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         tick();
         if (sw_en === 8'h07) hit = 1;
      end
      checks++;
      if (!hit) begin fails++; $display("FAIL abu_reach got=%h exp=07", sw_en); end
      pwr_req = 1'b0;
      for (int e = 0; e <= 6; e++) begin
         tick();
         n = 3 - e / 2;
         checks += 2;
         if (sw_en !== therm(n)) begin fails++; $display("FAIL abu_sw_en e=%0d got=%h exp=%h", e, sw_en, therm(n)); end
         if (iso_en !== 1'b1 || pwr_ack !== 1'b0) begin
            fails++; $display("FAIL abu_iso_ack e=%0d got=%b%b exp=10", e, iso_en, pwr_ack);
         end
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin fails++; $display("FAIL abu_off_busy got=%b exp=0", busy); end
   endtask

   task automatic test_abort_down();
      int n;
      bit hit;
      step_dly = 8'd0; pwr_req = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      checks++;
      if (pwr_ack !== 1'b1) begin fails++; $display("FAIL abd_on got=%b exp=1", pwr_ack); end
      pwr_req = 1'b0;
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         tick();
         if (sw_en === 8'h0F) hit = 1;
      end
      checks++;
      if (!hit) begin fails++; $display("FAIL abd_reach got=%h exp=0f", sw_en); end
      pwr_req = 1'b1;
      for (int e = 0; e <= 5; e++) begin
         tick();
         n = (e == 0) ? 4 : ((4 + e > N) ? N : 4 + e);
         checks += 2;
         if (sw_en !== therm(n))    begin fails++; $display("FAIL abd_sw_en e=%0d got=%h exp=%h", e, sw_en, therm(n)); end
         if (pwr_ack !== (e >= 5))  begin fails++; $display("FAIL abd_ack e=%0d got=%b exp=%b", e, pwr_ack, e >= 5); end
      end
   endtask

   task automatic test_reset_mid();
      bit hit;
      pwr_req = 1'b0;
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         tick();
         if (busy === 1'b0 && sw_en === '0) hit = 1;
      end
      checks++;
      if (!hit) begin fails++; $display("FAIL rm_off_reach got=%h exp=00", sw_en); end
      step_dly = 8'd2; pwr_req = 1'b1;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         tick();
         if (sw_en === 8'h3F) hit = 1;
      end
      checks++;
      if (!hit) begin fails++; $display("FAIL rm_reach got=%h exp=3f", sw_en); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks += 2;
      if (sw_en !== '0 || sw_cnt !== 4'd0) begin fails++; $display("FAIL rm_sw got=%h/%0d exp=00/0", sw_en, sw_cnt); end
      if (iso_en !== 1'b1 || pwr_ack !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL rm_ctrl got=%b%b%b exp=100", iso_en, pwr_ack, busy);
      end
      tick();
      checks++;
      if (sw_en !== 8'h01 || busy !== 1'b1) begin fails++; $display("FAIL rm_restart got=%h/%b exp=01/1", sw_en, busy); end
   endtask

   task automatic test_dly_change();
      bit hit;
      pwr_req = 1'b0;
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         tick();
         if (busy === 1'b0 && sw_en === '0) hit = 1;
      end
      checks++;
      if (!hit) begin fails++; $display("FAIL dc_off_reach got=%h exp=00", sw_en); end
      step_dly = 8'd5; pwr_req = 1'b1;
      tick();
      checks++;
      if (sw_en !== 8'h01) begin fails++; $display("FAIL dc_bit0 got=%h exp=01", sw_en); end
      tick(); tick();
      step_dly = 8'd0;
      tick(); tick(); tick();
      checks++;
      if (sw_en !== 8'h01) begin fails++; $display("FAIL dc_e5 got=%h exp=01", sw_en); end
      tick();
      checks++;
      if (sw_en !== 8'h03) begin fails++; $display("FAIL dc_e6 got=%h exp=03", sw_en); end
      tick();
      checks++;
      if (sw_en !== 8'h07) begin fails++; $display("FAIL dc_e7 got=%h exp=07", sw_en); end
      tick();
      checks++;
      if (sw_en !== 8'h0F) begin fails++; $display("FAIL dc_e8 got=%h exp=0f", sw_en); end
   endtask

   task automatic test_random();
      m_t = 0;
      for (int c = 0; c < 4000; c++) begin
         rst_n = (c == 0 || $urandom_range(299) == 0) ? 1'b0 : 1'b1;
         if ($urandom_range(19) == 0) pwr_req = ~pwr_req;
         if ($urandom_range(15) == 0) step_dly = DW'($urandom_range(3));
         tick();
         model_edge(pwr_req, step_dly, rst_n);
         checks += 4;
         if (sw_en !== therm(m_n)) begin fails++; $display("FAIL rnd_sw_en c=%0d got=%h exp=%h", c, sw_en, therm(m_n)); end
         if (sw_cnt !== 4'(m_n))   begin fails++; $display("FAIL rnd_sw_cnt c=%0d got=%0d exp=%0d", c, sw_cnt, m_n); end
         if (pwr_ack !== m_on || iso_en !== !m_on) begin
            fails++; $display("FAIL rnd_ack_iso c=%0d got=%b%b exp=%b%b", c, pwr_ack, iso_en, m_on, !m_on);
         end
         if (busy !== m_act)       begin fails++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_act); end
      end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_power_down();
      test_abort_up();
      test_abort_down();
      test_reset_mid();
      test_dly_change();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
